// File: rtl/tdc_hit_if.sv
// Hit record readout bus: FWFT head record, valid and consumer pop.
interface tdc_hit_if #(
    parameter int DATA_W = 29
) ();
    logic [DATA_W-1:0] hit_data;
    logic              hit_valid;
    logic              hit_ready;

    modport master (output hit_data, output hit_valid, input hit_ready);
    modport slave  (input hit_data, input hit_valid, output hit_ready);
endinterface

// File: rtl/tdc_hit_encoder.sv
// TDC hit encoder: first rise/fall edge finder on the fine-time sample word,
// coarse time stamping and a first-word-fall-through record FIFO.
module tdc_hit_encoder #(
    parameter int SAMPLES    = 32,
    parameter int COARSE_W   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic [SAMPLES-1:0]            sample,
    input  logic                          sample_valid,
    tdc_hit_if.master                     hit,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_cnt
);
    localparam int REC_W = COARSE_W + 13;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // Lowest set index of an edge vector; 0 when the vector is empty.
    function automatic logic [4:0] first_idx(input logic [SAMPLES-1:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = SAMPLES - 1; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

    // Free-running coarse time and last bit of the previous valid word
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic                prev_last_q, prev_last_d;

    // Valid shift: [0] word captured, [1] record pending write
    logic [1:0]          vld_pipe_q, vld_pipe_d;

    // Stage 0 capture
    logic [SAMPLES-1:0]  s0_word_q, s0_word_d;
    logic [COARSE_W-1:0] s0_coarse_q, s0_coarse_d;
    logic                s0_prev_q, s0_prev_d;
    logic                s0_en_q, s0_en_d;

    // Stage 1 encoded record
    logic [REC_W-1:0]    s1_rec_q, s1_rec_d;

    // FIFO storage and bookkeeping
    logic [FIFO_DEPTH-1:0][REC_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [7:0]          ovf_q, ovf_d;

    // Edge detection on the stage 0 word
    logic [SAMPLES-1:0]  prior_vec, rise_vec, fall_vec;
    logic                rise_any, fall_any, multi;
    logic                pop, wr_req, full, wr_ok;

    // Capture the incoming word and advance the coarse counter
    always_comb begin
        coarse_d    = coarse_q + COARSE_W'(1);
        prev_last_d = sample_valid ? sample[SAMPLES-1] : prev_last_q;
        s0_word_d   = sample_valid ? sample : s0_word_q;
        s0_coarse_d = sample_valid ? coarse_q : s0_coarse_q;
        s0_prev_d   = sample_valid ? prev_last_q : s0_prev_q;
        s0_en_d     = sample_valid ? enable : s0_en_q;
    end

    // Encode first rising/falling edges; the prior bit of sample 0 comes from the previous word
    always_comb begin
        prior_vec = {s0_word_q[SAMPLES-2:0], s0_prev_q};
        rise_vec  = s0_word_q & ~prior_vec;
        fall_vec  = ~s0_word_q & prior_vec;
        rise_any  = |rise_vec;
        fall_any  = |fall_vec;
        // More than one bit set <=> clearing the lowest set bit leaves something
        multi     = (|(rise_vec & (rise_vec - SAMPLES'(1)))) |
                    (|(fall_vec & (fall_vec - SAMPLES'(1))));
        s1_rec_d  = {multi, rise_any, fall_any, s0_coarse_q,
                     first_idx(rise_vec), first_idx(fall_vec)};
        vld_pipe_d[0] = sample_valid;
        // Only edge-bearing words sampled while enabled become records
        vld_pipe_d[1] = vld_pipe_q[0] & s0_en_q & (rise_any | fall_any);
    end

    // FIFO write/pop; a full FIFO still accepts a write when the head pops the same cycle
    always_comb begin
        pop      = (level_q != '0) & hit.hit_ready;
        wr_req   = vld_pipe_q[1];
        full     = (level_q == LVL_W'(FIFO_DEPTH));
        wr_ok    = wr_req & (~full | pop);
        mem_d    = mem_q;
        if (wr_ok) mem_d[wr_ptr_q] = s1_rec_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q;
        case ({wr_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q;
        if (wr_req && !wr_ok && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end

    // All state, synchronously cleared
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coarse_q    <= '0;
            prev_last_q <= 1'b0;
            vld_pipe_q  <= '0;
            s0_word_q   <= '0;
            s0_coarse_q <= '0;
            s0_prev_q   <= 1'b0;
            s0_en_q     <= 1'b0;
            s1_rec_q    <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= '0;
        end else begin
            coarse_q    <= coarse_d;
            prev_last_q <= prev_last_d;
            vld_pipe_q  <= vld_pipe_d;
            s0_word_q   <= s0_word_d;
            s0_coarse_q <= s0_coarse_d;
            s0_prev_q   <= s0_prev_d;
            s0_en_q     <= s0_en_d;
            s1_rec_q    <= s1_rec_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
        end
    end

    assign hit.hit_data  = mem_q[rd_ptr_q];
    assign hit.hit_valid = (level_q != '0);
    assign fifo_level    = level_q;
    assign overflow_cnt  = ovf_q;
endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Scoreboard bench: stimulus pushes expected records, monitors pop and compare.
module tb_tdc_hit_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic        a_rst_n, a_en, a_sv;
    logic [31:0] a_sample;
    logic [4:0]  a_lvl;
    logic [7:0]  a_ovf;
    tdc_hit_if #(.DATA_W(29)) a_if ();

    // DUT B: 4-bit coarse counter, 4-entry FIFO
    logic        b_rst_n, b_en, b_sv;
    logic [31:0] b_sample;
    logic [2:0]  b_lvl;
    logic [7:0]  b_ovf;
    tdc_hit_if #(.DATA_W(17)) b_if ();

    tdc_hit_encoder u_a (
        .clk(clk), .rst_n(a_rst_n), .enable(a_en), .sample(a_sample),
        .sample_valid(a_sv), .hit(a_if), .fifo_level(a_lvl), .overflow_cnt(a_ovf)
    );

    tdc_hit_encoder #(.COARSE_W(4), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst_n(b_rst_n), .enable(b_en), .sample(b_sample),
        .sample_valid(b_sv), .hit(b_if), .fifo_level(b_lvl), .overflow_cnt(b_ovf)
    );

    int checks = 0;
    int failures = 0;
    int ecnt_a = 0;
    int ecnt_b = 0;
    logic [28:0] qa[$];
    logic [16:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; counts released edges so expected coarse values follow the edge index
    task automatic tick();
        bit ra, rb;
        ra = a_rst_n;
        rb = b_rst_n;
        @(posedge clk);
        ecnt_a = ra ? ecnt_a + 1 : 0;
        ecnt_b = rb ? ecnt_b + 1 : 0;
        #1;
    endtask

    task automatic send_a(input logic [31:0] w, input bit en);
        a_sample = w; a_sv = 1'b1; a_en = en;
        tick();
    endtask

    task automatic idle_a(input int n);
        a_sv = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_b(input logic [31:0] w);
        b_sample = w; b_sv = 1'b1; b_en = 1'b1;
        tick();
    endtask

    task automatic idle_b(input int n);
        b_sv = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Expected record for the word about to be issued on DUT A (coarse = current edge index)
    task automatic exp_a(input bit m, input bit rf, input bit ff,
                         input logic [4:0] ri, input logic [4:0] fi);
        logic [15:0] c;
        c = ecnt_a[15:0];
        qa.push_back({m, rf, ff, c, ri, fi});
    endtask

    task automatic exp_b(input bit m, input bit rf, input bit ff, input logic [3:0] c,
                         input logic [4:0] ri, input logic [4:0] fi);
        qb.push_back({m, rf, ff, c, ri, fi});
    endtask

    // Monitor A: compare head record on every pop
    always @(negedge clk) begin
        if (a_rst_n && a_if.hit_valid && a_if.hit_ready) begin
            if (qa.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_record: got 0x%0h expected none", a_if.hit_data);
            end else begin
                chk("a_record", 32'(a_if.hit_data), 32'(qa.pop_front()));
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (b_rst_n && b_if.hit_valid && b_if.hit_ready) begin
            if (qb.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_record: got 0x%0h expected none", b_if.hit_data);
            end else begin
                chk("b_record", 32'(b_if.hit_data), 32'(qb.pop_front()));
            end
        end
    end

    initial begin
        a_rst_n = 1'b0; a_en = 1'b1; a_sv = 1'b1; a_sample = '0; a_if.hit_ready = 1'b0;
        b_rst_n = 1'b0; b_en = 1'b1; b_sv = 1'b0; b_sample = '0; b_if.hit_ready = 1'b0;

        // Reset with random samples
        for (int i = 0; i < 3; i++) begin
            a_sample = $urandom;
            tick();
        end
        chk("a_rst_valid", 32'(a_if.hit_valid), 0);
        chk("a_rst_level", 32'(a_lvl), 0);
        chk("a_rst_ovf",   32'(a_ovf), 0);
        chk("a_rst_data",  32'(a_if.hit_data), 0);

        // First released edge stamps coarse 0; 0x1 from prev 0: rise@0, fall@1
        a_rst_n = 1'b1; a_if.hit_ready = 1'b1;
        exp_a(0, 1, 0 | 1, 5'd0, 5'd1);
        send_a(32'h0000_0001, 1);
        idle_a(14);
        send_a(32'h0000_0000, 1);                 // edge 15, no record
        exp_a(0, 1, 0, 5'd8, 5'd0);               // coarse 0x0010
        send_a(32'hFFFF_FF00, 1);                 // edge 16
        chk("lat_n0", 32'(a_if.hit_valid), 0);
        send_a(32'hFFFF_FFFF, 1);                 // no edges
        chk("lat_n1", 32'(a_if.hit_valid), 0);
        exp_a(0, 0, 1, 5'd0, 5'd0);               // cross-word fall
        send_a(32'h0000_0000, 1);
        chk("lat_n2", 32'(a_if.hit_valid), 1);
        send_a(32'h0000_0000, 1);                 // repeat zero: no record
        exp_a(1, 1, 1, 5'd4, 5'd8);               // pulse pair, multi
        send_a(32'h00F0_00F0, 1);
        send_a(32'h00F0_00F0, 0);                 // disabled: no record
        send_a(32'h8000_0000, 0);                 // disabled, prev_last -> 1
        exp_a(0, 0, 1, 5'd0, 5'd0);               // fall@0 proves prev_last tracked
        send_a(32'h0000_0000, 1);
        a_sample = 32'hFFFF_FFFF; a_sv = 1'b0;    // invalid word must not touch prev_last
        tick();
        exp_a(0, 1, 0, 5'd0, 5'd0);
        send_a(32'hFFFF_FFFF, 1);
        idle_a(6);
        chk("a_drain_level", 32'(a_lvl), 0);
        chk("a_drain_queue", 32'(qa.size()), 0);

        // Overflow: 20 edge words into a 16-entry FIFO with no pops
        a_if.hit_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_a(0, 1, 1, 5'd16, 5'd8);
            send_a(32'hFFFF_00FF, 1);
        end
        idle_a(3);
        chk("ovf_level", 32'(a_lvl), 16);
        chk("ovf_count", 32'(a_ovf), 4);

        // Full with simultaneous pop and write
        exp_a(0, 1, 1, 5'd16, 5'd8);
        send_a(32'hFFFF_00FF, 1);
        idle_a(1);
        a_if.hit_ready = 1'b1;
        tick();
        a_if.hit_ready = 1'b0;
        chk("full_popwr_level", 32'(a_lvl), 16);
        chk("full_popwr_ovf",   32'(a_ovf), 4);
        a_if.hit_ready = 1'b1;
        idle_a(20);
        chk("ovf_drain_level", 32'(a_lvl), 0);
        chk("ovf_drain_ovf",   32'(a_ovf), 4);
        chk("ovf_drain_queue", 32'(qa.size()), 0);

        // Coarse wrap on the 4-bit instance
        b_rst_n = 1'b1; b_if.hit_ready = 1'b1;
        idle_b(15);
        exp_b(0, 1, 1, 4'd15, 5'd0, 5'd1);
        send_b(32'h0000_0001);
        exp_b(0, 1, 1, 4'd0, 5'd0, 5'd1);
        send_b(32'h0000_0001);
        idle_b(5);
        chk("wrap_level", 32'(b_lvl), 0);
        chk("wrap_queue", 32'(qb.size()), 0);

        // Reset with three records queued
        b_if.hit_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_b(32'h0000_0001);
        idle_b(2);
        chk("b_queued_level", 32'(b_lvl), 3);
        chk("b_queued_valid", 32'(b_if.hit_valid), 1);
        b_rst_n = 1'b0;
        tick();
        chk("b_rst_valid", 32'(b_if.hit_valid), 0);
        chk("b_rst_level", 32'(b_lvl), 0);
        chk("b_rst_ovf",   32'(b_ovf), 0);
        b_rst_n = 1'b1; b_if.hit_ready = 1'b1;
        idle_b(5);
        chk("b_post_rst_valid", 32'(b_if.hit_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
